pixel_frame_writer: RTL

PIXEL_FRAME_WRITER -- requirements
Module: pixel_frame_writer

---
 rtl/pixel_frame_writer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pixel_frame_writer.sv
// rtl/pixel_frame_writer.sv - banked frame buffer writer with registered flat-address readback
// Optional feature macro: PIXEL_WRITER_CHECKSUM_EN adds a running byte checksum output.
module pixel_frame_writer #(
   parameter int BANK_DEPTH = 65000,
   parameter int NUM_BANKS  = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic [19:0] rd_addr,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic        overflow
`ifdef PIXEL_WRITER_CHECKSUM_EN
   ,
   output logic [31:0] checksum
`endif
);

   localparam int OFF_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'(BANK_DEPTH - 1);
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t            state;
   state_t            nextState;
   logic [BANK_W-1:0] bankCnt;
   logic [OFF_W-1:0]  offCnt;
   logic              xfer;
   logic              lastBeat;
   logic [BANK_W-1:0] rdBank;
   logic [OFF_W-1:0]  rdOff;
   logic              rdHit;
   logic [31:0]       rdAddrW;

   logic [7:0] mem [NUM_BANKS][BANK_DEPTH];

   // A start pulse always wins, so any beat presented alongside it is dropped.
   assign xfer     = in_valid & in_ready & ~start;
   assign lastBeat = (bankCnt == LAST_BANK) && (offCnt == LAST_OFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: ;
         WRITE: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (xfer && lastBeat) begin
               nextState = DONE;
            end
         end
         DONE: done = 1'b1;
         default: nextState = IDLE;
      endcase
      if (start) begin
         nextState = WRITE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bankCnt  <= '0;
         offCnt   <= '0;
         overflow <= 1'b0;
      end else if (start) begin
         bankCnt  <= '0;
         offCnt   <= '0;
         overflow <= 1'b0;
      end else begin
         if (xfer) begin
            if (offCnt == LAST_OFF) begin
               offCnt  <= '0;
               bankCnt <= lastBeat ? '0 : bankCnt + 1'b1;
            end else begin
               offCnt <= offCnt + 1'b1;
            end
         end
         if (in_valid && !in_ready) begin
            overflow <= 1'b1;
         end
      end
   end

   // Frame contents survive reset, so the array has no reset branch.
   always_ff @(posedge clk) begin
      if (xfer) begin
         mem[bankCnt][offCnt] <= in_data;
      end
   end

   // Flat address -> (bank, offset) by range compare; out-of-frame reads return zero.
   always_comb begin
      rdAddrW = {12'd0, rd_addr};
      rdBank  = '0;
      rdOff   = '0;
      rdHit   = 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (rdAddrW >= 32'(i * BANK_DEPTH) && rdAddrW < 32'((i + 1) * BANK_DEPTH)) begin
            rdBank = BANK_W'(i);
            rdOff  = OFF_W'(rdAddrW - 32'(i * BANK_DEPTH));
            rdHit  = 1'b1;
         end
      end
   end

   // Sampled in the same edge as the write, so a colliding read returns the old byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else begin
         rd_data <= rdHit ? {24'd0, mem[rdBank][rdOff]} : 32'd0;
      end
   end

`ifdef PIXEL_WRITER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (start) begin
         checksum <= '0;
      end else if (xfer) begin
         checksum <= checksum + {24'd0, in_data};
      end
   end
`endif

endmodule
